// File: rtl/counter60_scan_driver_pkg.sv
// Shared constants for the mod-60 seconds counter and its display scan.
//   DIG_*     : active-low digit enable patterns ([0]=units, [1]=tens)
//   ONES_MAX  : last BCD value of the units digit
//   TENS_MAX  : last BCD value of the tens digit
//   presc_width(): register width needed to count 0..div-1
package counter60_scan_driver_pkg;

    localparam logic [1:0] DIG_UNITS = 2'b10;
    localparam logic [1:0] DIG_TENS  = 2'b01;
    localparam logic [1:0] DIG_OFF   = 2'b11;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [2:0] TENS_MAX = 3'd5;

    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/counter60_scan_driver_pulse_divider.sv
// pulse_divider: counts 0..DIV-1 while en is high and flags the terminal count.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset (count -> 0)
//   en     in  advance enable; low holds the count
//   clr    in  synchronous clear of the count (wins over en)
//   pulse  out high on the cycle whose rising edge wraps the count to 0
//              (combinational: en && count==DIV-1)
module pulse_divider
    import counter60_scan_driver_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic pulse
);

    localparam int             W    = presc_width(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign pulse = en && (cnt == LAST);

endmodule

// File: rtl/counter60_scan_driver.sv
// counter60_scan_driver: mod-60 BCD seconds counter with a two-digit scan mux.
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   count enable; low freezes the tick prescaler and the count
//   clr        in   synchronous clear of count and tick prescaler (beats a tick)
//   ones       out  BCD units digit 0..9
//   tens       out  BCD tens digit 0..5
//   carry      out  one-cycle pulse on the tick that wraps 59 -> 00
//   hex_out    out  digit value for the seven-segment decoder
//   digit_sel  out  active-low digit enables, [0]=units, [1]=tens
// The scan slot and both display outputs ignore en/clr; hex_out/digit_sel are
// registered one cycle behind the slot and count registers they are built from.
module counter60_scan_driver
    import counter60_scan_driver_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] ones,
    output logic [2:0] tens,
    output logic       carry,
    output logic [3:0] hex_out,
    output logic [1:0] digit_sel
);

    logic       tick;
    logic       scan_pulse;
    logic       slot;
    logic [3:0] hex_d;
    logic [1:0] sel_d;

    pulse_divider #(.DIV(TICK_DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .pulse (tick)
    );

    pulse_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .pulse (scan_pulse)
    );

    // BCD count; clr is checked first so a coincident tick is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones  <= '0;
            tens  <= '0;
            carry <= 1'b0;
        end else if (clr) begin
            ones  <= '0;
            tens  <= '0;
            carry <= 1'b0;
        end else if (tick) begin
            carry <= (ones == ONES_MAX) && (tens == TENS_MAX);
            if (ones == ONES_MAX) begin
                ones <= '0;
                tens <= (tens == TENS_MAX) ? '0 : tens + 3'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end else begin
            carry <= 1'b0;
        end
    end

    // Slot 0 shows units, slot 1 shows tens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= 1'b0;
        end else if (scan_pulse) begin
            slot <= ~slot;
        end
    end

    always_comb begin
        hex_d = ones;
        sel_d = DIG_UNITS;
        if (slot) begin
            hex_d = {1'b0, tens};
            sel_d = (LZ_BLANK && (tens == 3'd0)) ? DIG_OFF : DIG_TENS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out   <= 4'h0;
            digit_sel <= DIG_UNITS;
        end else begin
            hex_out   <= hex_d;
            digit_sel <= sel_d;
        end
    end

endmodule

// File: tb/tb_counter60_scan_driver.sv
module tb_counter60_scan_driver;

    localparam int TD = 4;
    localparam int SD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [3:0] ones,    ones_lz;
    logic [2:0] tens,    tens_lz;
    logic       carry,   carry_lz;
    logic [3:0] hex_out, hex_lz;
    logic [1:0] digit_sel, sel_lz;

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    counter60_scan_driver #(.TICK_DIV(TD), .SCAN_DIV(SD), .LZ_BLANK(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .ones(ones), .tens(tens), .carry(carry),
        .hex_out(hex_out), .digit_sel(digit_sel)
    );

    counter60_scan_driver #(.TICK_DIV(TD), .SCAN_DIV(SD), .LZ_BLANK(1'b1)) u_dut_lz (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .ones(ones_lz), .tens(tens_lz), .carry(carry_lz),
        .hex_out(hex_lz), .digit_sel(sel_lz)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Count kept as plain seconds 0..59; digits come from /10 and %10.
    int         m_secs, m_presc, m_scan, m_slot;
    bit         m_carry;
    int         m_hex;
    logic [1:0] m_sel, m_sel_lz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_secs = 0; m_presc = 0; m_scan = 0; m_slot = 0; m_carry = 0;
            m_hex = 0; m_sel = 2'b10; m_sel_lz = 2'b10;
        end else begin
            // display reflects the state held before this edge
            if (m_slot == 0) begin
                m_hex = m_secs % 10; m_sel = 2'b10; m_sel_lz = 2'b10;
            end else begin
                m_hex = m_secs / 10; m_sel = 2'b01;
                m_sel_lz = (m_secs / 10 == 0) ? 2'b11 : 2'b01;
            end
            m_carry = 0;
            if (clr) begin
                m_secs = 0; m_presc = 0;
            end else if (en) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    m_carry = (m_secs == 59);
                    m_secs  = (m_secs + 1) % 60;
                end else begin
                    m_presc++;
                end
            end
            if (m_scan == SD - 1) begin
                m_scan = 0; m_slot = 1 - m_slot;
            end else begin
                m_scan++;
            end
        end
    end

    // ---------------- scoreboard compare, every cycle out of reset ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("ones",      32'(ones),      32'(m_secs % 10));
            check("tens",      32'(tens),      32'(m_secs / 10));
            check("carry",     32'(carry),     32'(m_carry));
            check("hex_out",   32'(hex_out),   32'(m_hex));
            check("digit_sel", 32'(digit_sel), 32'(m_sel));
            check("lz_ones",   32'(ones_lz),   32'(m_secs % 10));
            check("lz_tens",   32'(tens_lz),   32'(m_secs / 10));
            check("lz_carry",  32'(carry_lz),  32'(m_carry));
            check("lz_hex",    32'(hex_lz),    32'(m_hex));
            check("lz_sel",    32'(sel_lz),    32'(m_sel_lz));
            check("hex_range", 32'(hex_out < 4'd10), 32'd1);
            check("sel_never_both", 32'(digit_sel != 2'b00 && sel_lz != 2'b00), 32'd1);
        end
    end

    // ---------------- directed + random stimulus ----------------
    int seen_a, seen_b, guard;

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ones",  32'(ones), 32'd0);
        check("rst_tens",  32'(tens), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_hex",   32'(hex_out), 32'd0);
        check("rst_sel",   32'(digit_sel), 32'(2'b10));

        // count from reset: 9 ticks in 36 cycles, 10th tick at 40
        rst_n = 1'b1; en = 1'b1;
        repeat (36) @(negedge clk);
        check("run36_ones", 32'(ones), 32'd9);
        check("run36_tens", 32'(tens), 32'd0);
        repeat (4) @(negedge clk);
        check("run40_ones", 32'(ones), 32'd0);
        check("run40_tens", 32'(tens), 32'd1);

        // clr coincident with the tick out of 12
        guard = 0;
        while (!(m_secs == 12 && m_presc == TD - 1) && guard < 500) begin
            @(negedge clk); guard++;
        end
        check("reach_12", 32'(guard < 500), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_ones",  32'(ones), 32'd0);
        check("clr_tens",  32'(tens), 32'd0);
        check("clr_carry", 32'(carry), 32'd0);
        repeat (3) @(negedge clk);
        check("clr_wait3", 32'(ones), 32'd0);
        @(negedge clk);
        check("clr_tick4", 32'(ones), 32'd1);

        // leading-zero blanking at 05, frozen so both slots are seen
        guard = 0;
        while (!(m_secs == 5 && m_presc == 1) && guard < 500) begin
            @(negedge clk); guard++;
        end
        check("reach_05", 32'(guard < 500), 32'd1);
        en = 1'b0;
        seen_a = 0; seen_b = 0;
        for (int i = 0; i < 8; i++) begin
            if (sel_lz == 2'b11) seen_a++;
            else if (sel_lz == 2'b10) begin
                seen_b++;
                check("lz_units_hex", 32'(hex_lz), 32'd5);
            end else check("lz_sel_val", 32'(sel_lz), 32'(2'b11));
            @(negedge clk);
        end
        check("lz_blank_seen", 32'(seen_a > 0), 32'd1);
        check("lz_units_seen", 32'(seen_b > 0), 32'd1);
        en = 1'b1;

        // hold at 23
        guard = 0;
        while (!(m_secs == 23 && m_presc == 0) && guard < 500) begin
            @(negedge clk); guard++;
        end
        check("reach_23", 32'(guard < 500), 32'd1);
        en = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_ones", 32'(ones), 32'd3);
        check("hold_tens", 32'(tens), 32'd2);
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_wait3", 32'(ones), 32'd3);
        @(negedge clk);
        check("hold_tick4", 32'(ones), 32'd4);

        // scan at 47: hex alternates 7/4 with digit_sel 10/01
        guard = 0;
        while (!(m_secs == 47 && m_presc == 1) && guard < 500) begin
            @(negedge clk); guard++;
        end
        check("reach_47", 32'(guard < 500), 32'd1);
        en = 1'b0;
        seen_a = 0; seen_b = 0;
        for (int i = 0; i < 6; i++) begin
            if (hex_out == 4'd7 && digit_sel == 2'b10) seen_a++;
            else if (hex_out == 4'd4 && digit_sel == 2'b01) seen_b++;
            else check("scan47_pair", 32'({hex_out, digit_sel}), 32'({4'd7, 2'b10}));
            @(negedge clk);
        end
        check("scan47_units", 32'(seen_a), 32'd3);
        check("scan47_tens",  32'(seen_b), 32'd3);
        en = 1'b1;

        // wrap 59 -> 00 with a single-cycle carry
        guard = 0;
        while (!(m_secs == 59 && m_presc == TD - 1) && guard < 500) begin
            @(negedge clk); guard++;
        end
        check("reach_59", 32'(guard < 500), 32'd1);
        check("pre_wrap_carry", 32'(carry), 32'd0);
        @(negedge clk);
        check("wrap_ones",  32'(ones), 32'd0);
        check("wrap_tens",  32'(tens), 32'd0);
        check("wrap_carry", 32'(carry), 32'd1);
        @(negedge clk);
        check("carry_drop", 32'(carry), 32'd0);

        // asynchronous reset mid-count, observed before the next clock edge
        repeat (22) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ones",  32'(ones), 32'd0);
        check("arst_tens",  32'(tens), 32'd0);
        check("arst_carry", 32'(carry), 32'd0);
        check("arst_sel",   32'(digit_sel), 32'(2'b10));
        check("arst_hex",   32'(hex_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized run with occasional clr and async reset
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
